sobel_window_3x3: RTL and testbench

//   Upstream stage of sobel_detector. Converts a raster pixel stream (row-major, one pixel per

---
 rtl/sobel_window_3x3_pkg.sv | 25 ++
 rtl/sobel_window_3x3_line_buffer.sv | 39 +++
 rtl/sobel_window_3x3.sv | 151 +++++++++++++++
 tb/tb_sobel_window_3x3.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sobel_window_3x3_pkg.sv
`default_nettype none
// ============================================================================
// Module  : sobel_window_3x3_pkg
// Purpose : Shared image geometry defaults and sizing helpers for the
//           3x3 window builder and later stages of the Sobel edge path.
// Contents: default DATA_W / IMG_WIDTH / IMG_HEIGHT, window tap count,
//           counter-width helper.
// Revision: 1.0 - initial release
// ============================================================================
package sobel_window_3x3_pkg;

    localparam int DEF_DATA_W     = 8;
    localparam int DEF_IMG_WIDTH  = 640;
    localparam int DEF_IMG_HEIGHT = 480;

    // Number of taps in a 3x3 neighbourhood
    localparam int WIN_TAPS = 9;

    // Width of a counter/address covering 0..n-1 (never narrower than 1 bit)
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage : sobel_window_3x3_pkg
`default_nettype wire

// File: rtl/sobel_window_3x3_line_buffer.sv
`default_nettype none
// ============================================================================
// Module  : sobel_window_3x3_line_buffer
// Purpose : One image line of storage. Single port, read-first: the read
//           data is the word currently stored at addr, and the write of
//           wr_data lands on the clock edge, so a same-cycle access returns
//           the previous line's pixel. RAM-inferable (no reset on storage).
// Ports   : clk      - clock, rising edge
//           we       - write enable
//           addr     - column address (read and write)
//           wr_data  - data written at addr on the clock edge
//           rd_data  - combinational read of the old contents at addr
// Revision: 1.0 - initial release
// ============================================================================
module sobel_window_3x3_line_buffer
    import sobel_window_3x3_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_IMG_WIDTH
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [cnt_w(DEPTH)-1:0]  addr,
    input  logic [DATA_W-1:0]        wr_data,
    output logic [DATA_W-1:0]        rd_data
);

    logic [DATA_W-1:0] r_mem [0:DEPTH-1];

    assign rd_data = r_mem[addr];

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[addr] <= wr_data;
        end
    end

endmodule : sobel_window_3x3_line_buffer
`default_nettype wire

// File: rtl/sobel_window_3x3.sv
`default_nettype none
// ============================================================================
// Module  : sobel_window_3x3
// Purpose : Turns a row-major raster pixel stream into 3x3 neighbourhood
//           windows. Two line buffers supply the two previous rows; a 3x3
//           register array shifts once per accepted pixel. Only fully
//           interior windows are flagged (no border padding).
// Ports   : clk, rst        - clock / asynchronous active-high reset
//           pix_in          - input pixel
//           pix_valid       - pixel accepted this cycle (no backpressure)
//           pix_sof         - with pix_valid: pixel is (row 0, col 0)
//           z0..z8          - window, row-major, z4 = centre, z8 = newest
//           win_valid       - one-cycle pulse: z0..z8 hold a new window
//           win_last        - with win_valid: last window of the frame
// Revision: 1.0 - initial release
// ============================================================================
module sobel_window_3x3
    import sobel_window_3x3_pkg::*;
#(
    parameter int IMG_WIDTH  = DEF_IMG_WIDTH,
    parameter int IMG_HEIGHT = DEF_IMG_HEIGHT,
    parameter int DATA_W     = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] pix_in,
    input  logic              pix_valid,
    input  logic              pix_sof,
    output logic [DATA_W-1:0] z0,
    output logic [DATA_W-1:0] z1,
    output logic [DATA_W-1:0] z2,
    output logic [DATA_W-1:0] z3,
    output logic [DATA_W-1:0] z4,
    output logic [DATA_W-1:0] z5,
    output logic [DATA_W-1:0] z6,
    output logic [DATA_W-1:0] z7,
    output logic [DATA_W-1:0] z8,
    output logic              win_valid,
    output logic              win_last
);

    localparam int COL_W = cnt_w(IMG_WIDTH);
    localparam int ROW_W = cnt_w(IMG_HEIGHT);

    localparam logic [COL_W-1:0] C_COL_LAST = COL_W'(IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0] C_ROW_LAST = ROW_W'(IMG_HEIGHT - 1);
    localparam logic [COL_W-1:0] C_COL_TWO  = COL_W'(2);
    localparam logic [ROW_W-1:0] C_ROW_TWO  = ROW_W'(2);

    logic [COL_W-1:0]  r_col;
    logic [ROW_W-1:0]  r_row;
    logic [COL_W-1:0]  w_col;
    logic [ROW_W-1:0]  w_row;
    logic              w_col_wrap;
    logic              w_row_wrap;
    logic              w_interior;
    logic              w_frame_end;
    logic [DATA_W-1:0] w_lb1_rd;
    logic [DATA_W-1:0] w_lb2_rd;
    logic [DATA_W-1:0] r_z [0:WIN_TAPS-1];
    logic              r_win_valid;
    logic              r_win_last;

    // Position of the pixel on the input this cycle; a start-of-frame pixel
    // is (0,0) regardless of where the counters had got to.
    always_comb begin
        w_col = r_col;
        w_row = r_row;
        if (pix_valid && pix_sof) begin
            w_col = '0;
            w_row = '0;
        end
    end

    assign w_col_wrap  = (w_col == C_COL_LAST);
    assign w_row_wrap  = (w_row == C_ROW_LAST);
    assign w_interior  = (w_row >= C_ROW_TWO) && (w_col >= C_COL_TWO);
    assign w_frame_end = w_row_wrap && w_col_wrap;

    // lb1 holds row r-1; its old word cascades into lb2, which holds row r-2.
    sobel_window_3x3_line_buffer #(
        .DATA_W  (DATA_W),
        .DEPTH   (IMG_WIDTH)
    ) u_lb1 (
        .clk     (clk),
        .we      (pix_valid),
        .addr    (w_col),
        .wr_data (pix_in),
        .rd_data (w_lb1_rd)
    );

    sobel_window_3x3_line_buffer #(
        .DATA_W  (DATA_W),
        .DEPTH   (IMG_WIDTH)
    ) u_lb2 (
        .clk     (clk),
        .we      (pix_valid),
        .addr    (w_col),
        .wr_data (w_lb1_rd),
        .rd_data (w_lb2_rd)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_col       <= '0;
            r_row       <= '0;
            r_win_valid <= 1'b0;
            r_win_last  <= 1'b0;
            for (int i = 0; i < WIN_TAPS; i++) begin
                r_z[i] <= '0;
            end
        end else begin
            r_win_valid <= pix_valid && w_interior;
            r_win_last  <= pix_valid && w_interior && w_frame_end;
            if (pix_valid) begin
                if (w_col_wrap) begin
                    r_col <= '0;
                    r_row <= w_row_wrap ? '0 : w_row + ROW_W'(1);
                end else begin
                    r_col <= w_col + COL_W'(1);
                    r_row <= w_row;
                end
                // Shift one column left; the new right column is
                // (row r-2, row r-1, row r) at the current column.
                r_z[0] <= r_z[1];
                r_z[1] <= r_z[2];
                r_z[2] <= w_lb2_rd;
                r_z[3] <= r_z[4];
                r_z[4] <= r_z[5];
                r_z[5] <= w_lb1_rd;
                r_z[6] <= r_z[7];
                r_z[7] <= r_z[8];
                r_z[8] <= pix_in;
            end
        end
    end

    assign z0        = r_z[0];
    assign z1        = r_z[1];
    assign z2        = r_z[2];
    assign z3        = r_z[3];
    assign z4        = r_z[4];
    assign z5        = r_z[5];
    assign z6        = r_z[6];
    assign z7        = r_z[7];
    assign z8        = r_z[8];
    assign win_valid = r_win_valid;
    assign win_last  = r_win_last;

endmodule : sobel_window_3x3
`default_nettype wire

// File: tb/tb_sobel_window_3x3.sv
`default_nettype none
// ============================================================================
// Module  : tb_sobel_window_3x3
// Purpose : Self-checking bench for sobel_window_3x3 on a 5x4 image.
//           A reference model stores each accepted pixel in an image array
//           at its raster position and predicts each interior window
//           directly from that array.
// Revision: 1.0 - initial release
// ============================================================================
module tb_sobel_window_3x3;

    localparam int W = 5;
    localparam int H = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] pix_in = '0;
    logic       pix_valid = 1'b0;
    logic       pix_sof = 1'b0;
    logic [7:0] z0, z1, z2, z3, z4, z5, z6, z7, z8;
    logic       win_valid;
    logic       win_last;

    int n_checks = 0;
    int n_pass   = 0;

    // reference model state
    int          m_r = 0;
    int          m_c = 0;
    logic [7:0]  img [0:H-1][0:W-1];
    logic        exp_valid;
    logic        exp_last;
    logic [71:0] exp_win;

    // observations
    logic        obs_valid;
    logic        obs_last;
    logic [71:0] obs_win;
    logic [71:0] prev_win;

    sobel_window_3x3 #(
        .IMG_WIDTH  (W),
        .IMG_HEIGHT (H),
        .DATA_W     (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .pix_in    (pix_in),
        .pix_valid (pix_valid),
        .pix_sof   (pix_sof),
        .z0        (z0),
        .z1        (z1),
        .z2        (z2),
        .z3        (z3),
        .z4        (z4),
        .z5        (z5),
        .z6        (z6),
        .z7        (z7),
        .z8        (z8),
        .win_valid (win_valid),
        .win_last  (win_last)
    );

    always #5 clk = ~clk;

    // One clock: drive inputs, advance the model, sample outputs 1 unit
    // after the edge.
    task automatic step(input logic v, input logic s, input logic [7:0] p);
        pix_valid = v;
        pix_sof   = s;
        pix_in    = p;
        @(posedge clk);
        exp_valid = 1'b0;
        exp_last  = 1'b0;
        if (v) begin
            if (s) begin
                m_r = 0;
                m_c = 0;
            end
            img[m_r][m_c] = p;
            if (m_r >= 2 && m_c >= 2) begin
                exp_valid = 1'b1;
                exp_last  = (m_r == H - 1) && (m_c == W - 1);
                exp_win   = {img[m_r-2][m_c-2], img[m_r-2][m_c-1], img[m_r-2][m_c],
                             img[m_r-1][m_c-2], img[m_r-1][m_c-1], img[m_r-1][m_c],
                             img[m_r][m_c-2],   img[m_r][m_c-1],   img[m_r][m_c]};
            end
            m_c++;
            if (m_c == W) begin
                m_c = 0;
                m_r = (m_r == H - 1) ? 0 : m_r + 1;
            end
        end
        #1;
        prev_win  = obs_win;
        obs_valid = win_valid;
        obs_last  = win_last;
        obs_win   = {z0, z1, z2, z3, z4, z5, z6, z7, z8};
        pix_valid = 1'b0;
        pix_sof   = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        obs_win = {z0, z1, z2, z3, z4, z5, z6, z7, z8};
        n_checks++;
        if (win_valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", win_valid);
        else n_pass++;
        n_checks++;
        if (win_last !== 1'b0) $display("FAIL reset_last: got %b expected 0", win_last);
        else n_pass++;
        n_checks++;
        if (obs_win !== 72'h0) $display("FAIL reset_window: got %h expected 0", obs_win);
        else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        m_r = 0;
        m_c = 0;
    endtask

    task automatic test_continuous();
        int nwin = 0;
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                step(1'b1, (r == 0 && c == 0), 8'(r * 16 + c));
                n_checks++;
                if (obs_valid !== exp_valid)
                    $display("FAIL cont_valid at (%0d,%0d): got %b expected %b", r, c, obs_valid, exp_valid);
                else n_pass++;
                if (exp_valid) begin
                    n_checks++;
                    if (obs_win !== exp_win || obs_last !== exp_last)
                        $display("FAIL cont_window: got %h/%b expected %h/%b", obs_win, obs_last, exp_win, exp_last);
                    else n_pass++;
                end
                if (obs_valid === 1'b1) begin
                    nwin++;
                    if (nwin == 1) begin
                        n_checks++;
                        if (obs_win !== 72'h00_01_02_10_11_12_20_21_22)
                            $display("FAIL cont_first: got %h expected 000102101112202122", obs_win);
                        else n_pass++;
                    end
                    if (nwin == 6) begin
                        n_checks++;
                        if (obs_win !== 72'h12_13_14_22_23_24_32_33_34 || obs_last !== 1'b1)
                            $display("FAIL cont_last: got %h/%b expected 121314222324323334/1", obs_win, obs_last);
                        else n_pass++;
                    end
                end
            end
        end
        n_checks++;
        if (nwin !== 6) $display("FAIL cont_count: got %0d expected 6", nwin);
        else n_pass++;
    endtask

    task automatic test_gaps();
        int nwin = 0;
        int gaps;
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                gaps = ($urandom_range(1, 0) == 1) ? $urandom_range(3, 1) : 0;
                for (int g = 0; g < gaps; g++) begin
                    step(1'b0, 1'b0, 8'($urandom));
                    n_checks++;
                    if (obs_valid !== 1'b0 || obs_win !== prev_win)
                        $display("FAIL gap_hold: got %b/%h expected 0/%h", obs_valid, obs_win, prev_win);
                    else n_pass++;
                end
                step(1'b1, (r == 0 && c == 0), 8'(r * 16 + c));
                n_checks++;
                if (obs_valid !== exp_valid)
                    $display("FAIL gap_valid at (%0d,%0d): got %b expected %b", r, c, obs_valid, exp_valid);
                else n_pass++;
                if (exp_valid) begin
                    n_checks++;
                    if (obs_win !== exp_win || obs_last !== exp_last)
                        $display("FAIL gap_window: got %h/%b expected %h/%b", obs_win, obs_last, exp_win, exp_last);
                    else n_pass++;
                end
                if (obs_valid === 1'b1) nwin++;
            end
        end
        n_checks++;
        if (nwin !== 6) $display("FAIL gap_count: got %0d expected 6", nwin);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int nwin = 0;
        for (int f = 0; f < 2; f++) begin
            for (int r = 0; r < H; r++) begin
                for (int c = 0; c < W; c++) begin
                    step(1'b1, (r == 0 && c == 0), 8'(f * 128 + r * 16 + c));
                    n_checks++;
                    if (obs_valid !== exp_valid)
                        $display("FAIL b2b_valid f%0d (%0d,%0d): got %b expected %b", f, r, c, obs_valid, exp_valid);
                    else n_pass++;
                    if (exp_valid) begin
                        n_checks++;
                        if (obs_win !== exp_win || obs_last !== exp_last)
                            $display("FAIL b2b_window: got %h/%b expected %h/%b", obs_win, obs_last, exp_win, exp_last);
                        else n_pass++;
                    end
                    if (obs_valid === 1'b1) begin
                        nwin++;
                        if (nwin == 7) begin
                            n_checks++;
                            if (obs_win !== 72'h80_81_82_90_91_92_A0_A1_A2)
                                $display("FAIL b2b_first2: got %h expected 808182909192a0a1a2", obs_win);
                            else n_pass++;
                        end
                    end
                end
            end
        end
        n_checks++;
        if (nwin !== 12) $display("FAIL b2b_count: got %0d expected 12", nwin);
        else n_pass++;
    endtask

    task automatic test_sof_mid();
        int nwin = 0;
        // partial frame: (0,0) .. (2,0)
        for (int i = 0; i < 2 * W + 1; i++) begin
            step(1'b1, (i == 0), 8'((i / W) * 16 + (i % W)));
            n_checks++;
            if (obs_valid !== 1'b0) $display("FAIL sofmid_partial: got %b expected 0", obs_valid);
            else n_pass++;
        end
        // new frame starts where (2,1) would have been
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                step(1'b1, (r == 0 && c == 0), 8'(8'h40 + r * 16 + c));
                n_checks++;
                if (obs_valid !== exp_valid)
                    $display("FAIL sofmid_valid at (%0d,%0d): got %b expected %b", r, c, obs_valid, exp_valid);
                else n_pass++;
                if (exp_valid) begin
                    n_checks++;
                    if (obs_win !== exp_win || obs_last !== exp_last)
                        $display("FAIL sofmid_window: got %h/%b expected %h/%b", obs_win, obs_last, exp_win, exp_last);
                    else n_pass++;
                end
                if (obs_valid === 1'b1) nwin++;
            end
        end
        n_checks++;
        if (nwin !== 6) $display("FAIL sofmid_count: got %0d expected 6", nwin);
        else n_pass++;
    endtask

    task automatic test_async_reset();
        int nwin = 0;
        // run up to (2,3) so a window is being presented when reset hits
        for (int i = 0; i < 2 * W + 4; i++) begin
            step(1'b1, (i == 0), 8'((i / W) * 16 + (i % W)));
        end
        n_checks++;
        if (obs_valid !== 1'b1) $display("FAIL arst_pre_valid: got %b expected 1", obs_valid);
        else n_pass++;
        #2;
        rst = 1'b1;
        #1;
        obs_win = {z0, z1, z2, z3, z4, z5, z6, z7, z8};
        n_checks++;
        if (win_valid !== 1'b0 || win_last !== 1'b0 || obs_win !== 72'h0)
            $display("FAIL arst_immediate: got %b/%b/%h expected 0/0/0", win_valid, win_last, obs_win);
        else n_pass++;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        m_r = 0;
        m_c = 0;
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                step(1'b1, 1'b0, 8'(8'h20 + r * 16 + c));
                n_checks++;
                if (obs_valid !== exp_valid)
                    $display("FAIL arst_valid at (%0d,%0d): got %b expected %b", r, c, obs_valid, exp_valid);
                else n_pass++;
                if (exp_valid) begin
                    n_checks++;
                    if (obs_win !== exp_win || obs_last !== exp_last)
                        $display("FAIL arst_window: got %h/%b expected %h/%b", obs_win, obs_last, exp_win, exp_last);
                    else n_pass++;
                end
                if (obs_valid === 1'b1) nwin++;
            end
        end
        n_checks++;
        if (nwin !== 6) $display("FAIL arst_count: got %0d expected 6", nwin);
        else n_pass++;
    endtask

    initial begin
        obs_win  = '0;
        prev_win = '0;
        exp_win  = '0;
        test_reset();
        test_continuous();
        test_gaps();
        test_back_to_back();
        test_sof_mid();
        test_async_reset();
        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_sobel_window_3x3
`default_nettype wire
